// File: rtl/rt_pkg.sv
// rt_pkg: shared fixed-point vector types, arithmetic helpers and FSM states for ray_plane_intersect.
package rt_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [2:0][31:0] vec3_t;

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE, S_NORM, S_DOT, S_DIV, S_PHIT, S_DONE
    } rpi_state_t;

    function automatic logic [31:0] fx_mul(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(p >>> FRAC_BITS);
    endfunction

    function automatic logic [31:0] dot3(input vec3_t a, input vec3_t b);
        return fx_mul(a[0], b[0]) + fx_mul(a[1], b[1]) + fx_mul(a[2], b[2]);
    endfunction

    function automatic vec3_t cross3(input vec3_t a, input vec3_t b);
        vec3_t r;
        r[0] = fx_mul(a[1], b[2]) - fx_mul(a[2], b[1]);
        r[1] = fx_mul(a[2], b[0]) - fx_mul(a[0], b[2]);
        r[2] = fx_mul(a[0], b[1]) - fx_mul(a[1], b[0]);
        return r;
    endfunction

    function automatic vec3_t vsub(input vec3_t a, input vec3_t b);
        vec3_t r;
        for (int i = 0; i < 3; i++) r[i] = a[i] - b[i];
        return r;
    endfunction

    function automatic vec3_t vadd(input vec3_t a, input vec3_t b);
        vec3_t r;
        for (int i = 0; i < 3; i++) r[i] = a[i] + b[i];
        return r;
    endfunction

    // a + t*d, the point along a ray at parameter t
    function automatic vec3_t vmad(input vec3_t a, input logic [31:0] t, input vec3_t d);
        vec3_t s;
        for (int i = 0; i < 3; i++) s[i] = fx_mul(t, d[i]);
        return vadd(a, s);
    endfunction

endpackage

// File: rtl/rp_divider.sv
// rp_divider: unsigned restoring divider, one quotient bit per cycle MSB first.
// The start cycle already resolves the first bit, so the quotient is ready ITERS edges after start.
module rp_divider
    import rt_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [63:0]      dividend_i,
    input  logic [31:0]      divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ITERS-1:0] quot_o
);

    localparam int CW = $clog2(ITERS + 1);

    logic [31:0]      rem_q, rem_d, dvs_q, dvs, src_rem;
    logic [ITERS-1:0] sh_q, sh_d, src_sh;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, ge;
    logic [32:0]      trial;

    // The caller guarantees dividend>>ITERS < divisor, so the initial remainder fits in 32 bits
    always_comb begin
        src_rem = start_i ? 32'(dividend_i >> ITERS) : rem_q;
        src_sh  = start_i ? dividend_i[ITERS-1:0] : sh_q;
        dvs     = start_i ? divisor_i : dvs_q;
        trial   = {src_rem, src_sh[ITERS-1]};
        ge      = trial >= {1'b0, dvs};
        rem_d   = ge ? 32'(trial - {1'b0, dvs}) : trial[31:0];
        sh_d    = {src_sh[ITERS-2:0], ge};
        cnt_d   = start_i ? CW'(1) : cnt_q + 1'b1;
        busy_d  = start_i || (busy_q && cnt_q != CW'(ITERS - 1));
        done_d  = busy_q && cnt_q == CW'(ITERS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            sh_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (start_i || busy_q) begin
                rem_q <= rem_d;
                sh_q  <= sh_d;
                dvs_q <= dvs;
                cnt_q <= cnt_d;
            end
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = sh_q;

endmodule

// File: rtl/ray_plane_intersect.sv
// ray_plane_intersect: multi-cycle ray/triangle-plane intersection producing p_hit, normal, t and
// the captured vertices as one coherent result for the inside-triangle stage.
module ray_plane_intersect
    import rt_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  vec3_t       ray_origin,
    input  vec3_t       ray_dir,
    input  vec3_t       v0,
    input  vec3_t       v1,
    input  vec3_t       v2,
    output logic        out_valid,
    input  logic        out_ready,
    output vec3_t       p_hit,
    output vec3_t       normal,
    output vec3_t       out_v0,
    output vec3_t       out_v1,
    output vec3_t       out_v2,
    output logic [31:0] t_hit,
    output logic        hit
);

    rpi_state_t     state_q, state_d;
    vec3_t          o_q, o_d, dir_q, dir_d, v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    vec3_t          e0_q, e0_d, e1_q, e1_d, w_q, w_d, n_q, n_d, p_q, p_d;
    logic [31:0]    t_q, t_d, denom, numer, mag_n, mag_d, quot_t;
    logic           hit_q, hit_d, neg_q, neg_d, valid_q, valid_d;
    logic           ovf, div_start, div_busy, div_done;
    logic [63:0]    dividend;
    logic [DIV_ITERS-1:0] quot;

    assign denom    = dot3(n_q, dir_q);
    assign numer    = dot3(n_q, w_q);
    assign mag_n    = numer[31] ? -numer : numer;
    assign mag_d    = denom[31] ? -denom : denom;
    // Quotient must stay below 2^31 so the signed result cannot wrap
    assign ovf      = (mag_n >> (31 - FRAC_BITS)) >= mag_d;
    assign dividend = {32'b0, mag_n} << FRAC_BITS;
    assign quot_t   = neg_q ? -32'(quot) : 32'(quot);
    assign in_ready = state_q == S_IDLE && !div_busy && !rst;

    rp_divider #(.ITERS(DIV_ITERS)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (mag_d),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (quot)
    );

    always_comb begin
        state_d   = state_q;
        o_d       = o_q;
        dir_d     = dir_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        e0_d      = e0_q;
        e1_d      = e1_q;
        w_d       = w_q;
        n_d       = n_q;
        p_d       = p_q;
        t_d       = t_q;
        hit_d     = hit_q;
        neg_d     = neg_q;
        div_start = 1'b0;
        unique case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
                o_d     = ray_origin;
                dir_d   = ray_dir;
                v0_d    = v0;
                v1_d    = v1;
                v2_d    = v2;
                state_d = S_EDGE;
            end
            S_EDGE: begin
                e0_d    = vsub(v1_q, v0_q);
                e1_d    = vsub(v2_q, v0_q);
                w_d     = vsub(v0_q, o_q);
                state_d = S_NORM;
            end
            S_NORM: begin
                n_d     = cross3(e0_q, e1_q);
                state_d = S_DOT;
            end
            S_DOT: begin
                neg_d = numer[31] ^ denom[31];
                if (denom == '0 || ovf) begin
                    t_d     = denom == '0 ? 32'h0 : 32'h7FFF_FFFF;
                    hit_d   = 1'b0;
                    state_d = S_PHIT;
                end else begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: if (div_done) begin
                t_d     = quot_t;
                hit_d   = !quot_t[31] && quot_t != '0;
                state_d = S_PHIT;
            end
            S_PHIT: begin
                p_d     = vmad(o_q, t_q, dir_q);
                state_d = S_DONE;
            end
            S_DONE: if (valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // valid is registered one cycle into DONE and drops on the handshake edge
        valid_d = state_q == S_DONE && !(valid_q && out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            dir_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
            w_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            t_q     <= '0;
            hit_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            dir_q   <= dir_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            w_q     <= w_d;
            n_q     <= n_d;
            p_q     <= p_d;
            t_q     <= t_d;
            hit_q   <= hit_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign p_hit     = p_q;
    assign normal    = n_q;
    assign out_v0    = v0_q;
    assign out_v1    = v1_q;
    assign out_v2    = v2_q;
    assign t_hit     = t_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_ray_plane_intersect.sv
// tb_ray_plane_intersect: directed vectors with hand-computed results, latency, backpressure and reset.
module tb_ray_plane_intersect;
    import rt_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    vec3_t       ray_origin = '0, ray_dir = '0, v0 = '0, v1 = '0, v2 = '0;
    logic        in_ready, out_valid, hit;
    vec3_t       p_hit, normal, out_v0, out_v1, out_v2;
    logic [31:0] t_hit;
    int          n_checks = 0, n_fail = 0;

    localparam logic [31:0] ONE = 32'h0001_0000;

    ray_plane_intersect dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ray_origin(ray_origin), .ray_dir(ray_dir), .v0(v0), .v1(v1), .v2(v2),
        .out_valid(out_valid), .out_ready(out_ready), .p_hit(p_hit), .normal(normal),
        .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2), .t_hit(t_hit), .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec3_t vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {z, y, x};
    endfunction

    task automatic run(input string tag, input vec3_t o, input vec3_t d, input vec3_t a,
                       input vec3_t b, input vec3_t c, input vec3_t exp_n, input logic [31:0] exp_t,
                       input vec3_t exp_p, input logic exp_hit, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        ray_origin = o; ray_dir = d; v0 = a; v1 = b; v2 = c; in_valid = 1'b1;
        check($sformatf("%s.in_ready", tag), 96'(in_ready), 96'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ray_origin = vec(32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D);
        ray_dir = ray_origin; v0 = ray_origin; v1 = ray_origin; v2 = ray_origin;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s.latency", tag), 96'(lat), 96'(exp_lat));
        for (int i = 0; i <= hold; i++) begin
            check($sformatf("%s.out_valid[%0d]", tag, i), 96'(out_valid), 96'(1));
            check($sformatf("%s.in_ready_busy[%0d]", tag, i), 96'(in_ready), 96'(0));
            check($sformatf("%s.normal[%0d]", tag, i), normal, exp_n);
            check($sformatf("%s.t_hit[%0d]", tag, i), 96'(t_hit), 96'(exp_t));
            check($sformatf("%s.p_hit[%0d]", tag, i), p_hit, exp_p);
            check($sformatf("%s.hit[%0d]", tag, i), 96'(hit), 96'(exp_hit));
            check($sformatf("%s.verts[%0d]", tag, i), out_v0 ^ {out_v1[1:0], out_v1[2]} ^ {out_v2[0], out_v2[2:1]},
                  a ^ {b[1:0], b[2]} ^ {c[0], c[2:1]});
            if (i < hold) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("%s.valid_drop", tag), 96'(out_valid), 96'(0));
        check($sformatf("%s.in_ready_after", tag), 96'(in_ready), 96'(1));
    endtask

    initial begin
        vec3_t zero, tv0, tv1, tv2, nz, p5;
        zero = '0;
        tv0 = vec(0, 0, 5 * ONE);
        tv1 = vec(ONE, 0, 5 * ONE);
        tv2 = vec(0, ONE, 5 * ONE);
        nz = vec(0, 0, ONE);
        p5 = vec(0, 0, 32'h0005_0000);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset.in_ready", 96'(in_ready), 96'(1));
        check("reset.out_valid", 96'(out_valid), 96'(0));
        check("reset.hit", 96'(hit), 96'(0));
        check("reset.t_hit", 96'(t_hit), 96'(0));
        check("reset.p_hit", p_hit, 96'(0));
        check("reset.normal", normal, 96'(0));
        check("reset.verts", out_v0 | out_v1 | out_v2, 96'(0));

        run("basic", zero, nz, tv0, tv1, tv2, nz, 32'h0005_0000, p5, 1'b1, 37, 0);
        run("parallel", zero, vec(ONE, 0, 0), tv0, tv1, tv2, nz, 32'h0, zero, 1'b0, 5, 0);
        run("behind", vec(0, 0, 10 * ONE), nz, tv0, tv1, tv2, nz, 32'hFFFB_0000, p5, 1'b0, 37, 0);
        run("overflow", zero, vec(0, 0, 1), tv0, tv1, tv2, nz, 32'h7FFF_FFFF,
            vec(0, 0, 32'h0000_7FFF), 1'b0, 5, 0);
        run("half_t", zero, vec(0, 0, 2 * ONE), tv0, tv1, tv2, nz, 32'h0002_8000, p5, 1'b1, 37, 0);
        run("neg_denom", vec(0, 0, 10 * ONE), vec(0, 0, -ONE), tv0, tv1, tv2, nz, 32'h0005_0000,
            p5, 1'b1, 37, 0);
        run("trunc_pos", zero, vec(0, 0, 3 * ONE), tv0, tv1, tv2, nz, 32'h0001_AAAA,
            vec(0, 0, 32'h0004_FFFE), 1'b1, 37, 0);
        run("trunc_neg", vec(0, 0, 10 * ONE), vec(0, 0, 3 * ONE), tv0, tv1, tv2, nz, 32'hFFFE_5556,
            vec(0, 0, 32'h0005_0002), 1'b0, 37, 0);
        run("scaled_n", vec(32'h8000, 32'h8000, 0), nz, vec(ONE, 2 * ONE, 5 * ONE),
            vec(3 * ONE, 2 * ONE, 5 * ONE), vec(ONE, 5 * ONE, 5 * ONE), vec(0, 0, 6 * ONE),
            32'h0005_0000, vec(32'h8000, 32'h8000, 32'h0005_0000), 1'b1, 37, 0);
        run("backpressure", zero, nz, tv0, tv1, tv2, nz, 32'h0005_0000, p5, 1'b1, 37, 10);

        @(negedge clk);
        ray_origin = zero; ray_dir = nz; v0 = tv0; v1 = tv1; v2 = tv2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst.out_valid", 96'(out_valid), 96'(0));
        check("midrst.t_hit", 96'(t_hit), 96'(0));
        check("midrst.p_hit", p_hit, 96'(0));
        check("midrst.normal", normal, 96'(0));
        check("midrst.verts", out_v0 | out_v1 | out_v2, 96'(0));
        check("midrst.hit", 96'(hit), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.in_ready", 96'(in_ready), 96'(1));
        repeat (40) begin
            @(posedge clk);
            #1;
            check("midrst.no_stale_out", 96'(out_valid), 96'(0));
        end
        run("after_rst", zero, nz, tv0, tv1, tv2, nz, 32'h0005_0000, p5, 1'b1, 37, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
